obstacle_mover: RTL and testbench

//  Parametrised obstacle engine for the 160x120 VGA adapter path. Animates one

---
 rtl/obstacle_mover_if.sv | 21 ++
 rtl/obstacle_mover.sv | 165 ++++++++++++++++
 tb/tb_obstacle_mover.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/obstacle_mover_if.sv
// Pixel write port between the obstacle engine and the VGA adapter, with
// the animation enable and status flags travelling alongside it.
interface obstacle_mover_if;
  logic       enable;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour_out;
  logic       plot;
  logic       busy;
  logic       wrapped;

  modport master (
    input  enable,
    output x, y, colour_out, plot, busy, wrapped
  );

  modport slave (
    output enable,
    input  x, y, colour_out, plot, busy, wrapped
  );
endinterface

// File: rtl/obstacle_mover.sv
// Animates one rectangular obstacle along a horizontal lane: draw, wait for a
// movement step, erase, move (with wrap), redraw. One registered pixel per cycle.
//
// state | meaning
// IDLE  | after reset, waiting for the first enable
// DRAW  | plotting the object at pos_x in OBJ_COLOUR
// WAIT  | object on screen, waiting for a pending step while enabled
// ERASE | plotting the object at pos_x in BG_COLOUR
// MOVE  | one cycle, advance or wrap pos_x
module obstacle_mover #(
  parameter int         OBJ_W           = 4,
  parameter int         OBJ_H           = 4,
  parameter int         SCREEN_W        = 160,
  parameter int         START_X         = 10,
  parameter int         START_Y         = 58,
  parameter logic [2:0] OBJ_COLOUR      = 3'd2,
  parameter logic [2:0] BG_COLOUR       = 3'd0,
  parameter int         TICKS_PER_FRAME = 833333,
  parameter int         FRAMES_PER_STEP = 15,
  parameter int         STEP            = 1,
  parameter int         DIR             = 0
) (
  input logic              clock,
  input logic              resetn,
  obstacle_mover_if.master vga
);

  localparam int DIV_W = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;
  localparam int FRM_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICKS_PER_FRAME - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(FRAMES_PER_STEP - 1);
  localparam logic [8:0]       MAX_X    = 9'(SCREEN_W - OBJ_W);
  localparam logic [8:0]       STEP_X   = 9'(STEP);
  localparam logic [8:0]       START_X9 = 9'(START_X);
  localparam logic [6:0]       START_Y7 = 7'(START_Y);
  localparam logic [3:0]       LAST_COL = 4'(OBJ_W - 1);
  localparam logic [3:0]       LAST_ROW = 4'(OBJ_H - 1);

  typedef enum logic [2:0] {IDLE, DRAW, WAIT, ERASE, MOVE} state_t;

  state_t           state_q, state_d;
  logic [8:0]       pos_x_q, pos_x_d;
  logic [3:0]       col_q, col_d;
  logic [3:0]       row_q, row_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [FRM_W-1:0] frm_q, frm_d;
  logic             pending_q, pending_d;
  logic [7:0]       x_q, x_d;
  logic [6:0]       y_q, y_d;
  logic [2:0]       colour_q, colour_d;
  logic             plot_q, plot_d;
  logic             busy_q, busy_d;
  logic             wrapped_q, wrapped_d;

  logic       tick, frame_wrap, last_pix, will_wrap, pending_clr;
  logic [8:0] next_x;

  always_comb begin
    state_d     = state_q;
    pos_x_d     = pos_x_q;
    col_d       = col_q;
    row_d       = row_q;
    x_d         = x_q;
    y_d         = y_q;
    colour_d    = colour_q;
    plot_d      = 1'b0;
    wrapped_d   = 1'b0;
    pending_clr = 1'b0;

    tick       = vga.enable && (div_q == DIV_LAST);
    frame_wrap = tick && (frm_q == FRM_LAST);
    div_d      = vga.enable ? (tick ? '0 : div_q + 1'b1) : div_q;
    frm_d      = tick ? (frame_wrap ? '0 : frm_q + 1'b1) : frm_q;
    last_pix   = (col_q == LAST_COL) && (row_q == LAST_ROW);

    if (DIR == 0) begin
      will_wrap = (pos_x_q + STEP_X) > MAX_X;
      next_x    = will_wrap ? 9'd0 : pos_x_q + STEP_X;
    end else begin
      will_wrap = pos_x_q < STEP_X;
      next_x    = will_wrap ? MAX_X : pos_x_q - STEP_X;
    end

    unique case (state_q)
      IDLE: if (vga.enable) state_d = DRAW;
      DRAW, ERASE: begin
        plot_d   = 1'b1;
        x_d      = 8'(pos_x_q + {5'd0, col_q});
        y_d      = START_Y7 + {3'd0, row_q};
        colour_d = (state_q == DRAW) ? OBJ_COLOUR : BG_COLOUR;
        if (col_q == LAST_COL) begin
          col_d = 4'd0;
          row_d = row_q + 4'd1;
        end else begin
          col_d = col_q + 4'd1;
        end
        if (last_pix) begin
          row_d = 4'd0;
          if (state_q == DRAW) begin
            state_d = WAIT;
          end else begin
            state_d   = MOVE;
            wrapped_d = will_wrap;
          end
        end
      end
      WAIT: begin
        if (pending_q && vga.enable) begin
          state_d     = ERASE;
          pending_clr = 1'b1;
        end
      end
      MOVE: begin
        pos_x_d = next_x;
        state_d = DRAW;
      end
      default: state_d = IDLE;
    endcase

    // A step landing in the same cycle that ERASE starts must not be lost.
    pending_d = frame_wrap ? 1'b1 : (pending_clr ? 1'b0 : pending_q);
    busy_d    = (state_d == DRAW) || (state_d == ERASE) || (state_d == MOVE);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      pos_x_q   <= START_X9;
      col_q     <= 4'd0;
      row_q     <= 4'd0;
      div_q     <= '0;
      frm_q     <= '0;
      pending_q <= 1'b0;
      x_q       <= START_X9[7:0];
      y_q       <= START_Y7;
      colour_q  <= BG_COLOUR;
      plot_q    <= 1'b0;
      busy_q    <= 1'b0;
      wrapped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_x_q   <= pos_x_d;
      col_q     <= col_d;
      row_q     <= row_d;
      div_q     <= div_d;
      frm_q     <= frm_d;
      pending_q <= pending_d;
      x_q       <= x_d;
      y_q       <= y_d;
      colour_q  <= colour_d;
      plot_q    <= plot_d;
      busy_q    <= busy_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign vga.x          = x_q;
  assign vga.y          = y_q;
  assign vga.colour_out = colour_q;
  assign vga.plot       = plot_q;
  assign vga.busy       = busy_q;
  assign vga.wrapped    = wrapped_q;

endmodule

// File: tb/tb_obstacle_mover.sv
// Directed bench: a right-moving and a left-moving instance on a tiny 8-wide
// screen, checked cycle by cycle against hand-computed pixel sequences.
module tb_obstacle_mover;

  logic clock = 1'b0;
  logic rst_r, rst_l;
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   sx, sy, sc, sp, sb, sw;

  always #5 clock = ~clock;

  obstacle_mover_if ifr ();
  obstacle_mover_if ifl ();

  obstacle_mover #(
    .OBJ_W(2), .OBJ_H(2), .SCREEN_W(8), .START_X(5), .START_Y(3),
    .OBJ_COLOUR(3'd2), .BG_COLOUR(3'd0), .TICKS_PER_FRAME(4),
    .FRAMES_PER_STEP(2), .STEP(1), .DIR(0)
  ) u_right (.clock(clock), .resetn(rst_r), .vga(ifr));

  obstacle_mover #(
    .OBJ_W(2), .OBJ_H(2), .SCREEN_W(8), .START_X(0), .START_Y(3),
    .OBJ_COLOUR(3'd2), .BG_COLOUR(3'd0), .TICKS_PER_FRAME(4),
    .FRAMES_PER_STEP(2), .STEP(1), .DIR(1)
  ) u_left (.clock(clock), .resetn(rst_l), .vga(ifl));

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic sample(input int s);
    if (s == 0) begin
      sx = int'(ifr.x); sy = int'(ifr.y); sc = int'(ifr.colour_out);
      sp = int'(ifr.plot); sb = int'(ifr.busy); sw = int'(ifr.wrapped);
    end else begin
      sx = int'(ifl.x); sy = int'(ifl.y); sc = int'(ifl.colour_out);
      sp = int'(ifl.plot); sb = int'(ifl.busy); sw = int'(ifl.wrapped);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic idle_to(input int s, input int c);
    while (cyc < c) begin
      step();
      sample(s);
      check("idle_plot", sp, 0);
    end
  endtask

  // npix pixels of a 2x2 pass at x0; optionally drop the right enable after the first
  task automatic pass(input int s, input int x0, input int col, input int npix, input bit drop);
    for (int i = 0; i < npix; i++) begin
      step();
      sample(s);
      check("pass_plot", sp, 1);
      check("pass_x", sx, x0 + (i % 2));
      check("pass_y", sy, 3 + (i / 2));
      check("pass_colour", sc, col);
      if (drop && i == 0) ifr.enable = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    rst_r = 1'b1; rst_l = 1'b1;
    ifr.enable = 1'b0; ifl.enable = 1'b0;
    #2;
    rst_r = 1'b0; rst_l = 1'b0;
    repeat (3) @(negedge clock);

    sample(0);
    check("rst_x", sx, 5);
    check("rst_y", sy, 3);
    check("rst_colour", sc, 0);
    check("rst_plot", sp, 0);
    check("rst_busy", sb, 0);
    check("rst_wrapped", sw, 0);
    sample(1);
    check("rst_l_x", sx, 0);

    // Right mover: first draw, then a step every 8 enabled clocks
    @(negedge clock);
    rst_r = 1'b1; ifr.enable = 1'b1; cyc = 0;
    idle_to(0, 1);
    pass(0, 5, 2, 4, 1'b0);
    check("draw_done_busy", sb, 0);
    idle_to(0, 9);
    pass(0, 5, 0, 4, 1'b0);
    check("move1_busy", sb, 1);
    check("move1_wrapped", sw, 0);
    idle_to(0, 14);
    pass(0, 6, 2, 4, 1'b0);
    idle_to(0, 19);
    pass(0, 6, 0, 4, 1'b0);
    check("move2_wrapped", sw, 1);
    idle_to(0, 24);
    check("move2_wrapped_drop", sw, 0);
    pass(0, 0, 2, 4, 1'b0);

    // Enable dropped mid-erase: pass, move and redraw complete, then freeze
    idle_to(0, 29);
    pass(0, 0, 0, 4, 1'b1);
    check("move3_wrapped", sw, 0);
    idle_to(0, 34);
    pass(0, 1, 2, 4, 1'b0);
    idle_to(0, 58);
    check("frozen_busy", sb, 0);
    ifr.enable = 1'b1;
    idle_to(0, 61);
    pass(0, 1, 0, 4, 1'b0);

    // Reset mid-draw takes effect without a clock edge
    idle_to(0, 66);
    pass(0, 2, 2, 2, 1'b0);
    rst_r = 1'b0;
    #1;
    sample(0);
    check("midrst_plot", sp, 0);
    check("midrst_x", sx, 5);
    check("midrst_y", sy, 3);
    check("midrst_busy", sb, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      sample(0);
      check("inrst_plot", sp, 0);
    end

    // Left mover from x=0: the first move wraps to SCREEN_W-OBJ_W
    @(negedge clock);
    rst_l = 1'b1; ifl.enable = 1'b1; cyc = 0;
    idle_to(1, 1);
    pass(1, 0, 2, 4, 1'b0);
    check("l_draw_busy", sb, 0);
    idle_to(1, 9);
    pass(1, 0, 0, 4, 1'b0);
    check("l_move_wrapped", sw, 1);
    idle_to(1, 14);
    check("l_wrapped_drop", sw, 0);
    pass(1, 6, 2, 4, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
